lvds_to_parallel: RTL

- 7:1 LVDS receiver; the inverse of the RGB-to-LVDS serializer path.
- Samples the three data lines and the forwarded LVDS clock line once per fast bit clock.
- Locks onto the 7-slot clock pattern, deserializes each line into 7-bit words, and unpacks them into rgb/de/vsync/hsync.
- Used as the loopback checker and panel-side model on the test board, in the same domain as the serializer PLL output.

---
 rtl/lvds_pkg.sv | 53 +++++
 rtl/lvds_to_parallel_if.sv | 23 ++
 rtl/lvds_deser_lane.sv | 42 ++++
 rtl/lvds_to_parallel.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
// Shared constants for the 7:1 LVDS link: lane numbering, clock-line pattern,
// slot positions of every pixel signal, receiver state encoding and word unpacking.
package lvds_pkg;
  localparam int NUM_LANES = 4;
  localparam int WORD_W    = 7;

  localparam int LANE_CLK = 0;
  localparam int LANE_1   = 1;
  localparam int LANE_2   = 2;
  localparam int LANE_3   = 3;

  // Bit index == slot number, slot 0 is the oldest sample of a word.
  localparam logic [WORD_W-1:0] CLK_PATTERN = 7'b1100011;

  localparam int SLOT_DE    = 0;  // line 3
  localparam int SLOT_VSYNC = 1;  // line 3
  localparam int SLOT_HSYNC = 2;  // line 3
  localparam int SLOT_RGB7  = 3;  // line 3
  localparam int SLOT_RGB6  = 4;  // line 3
  localparam int SLOT_RGB5  = 5;  // line 3
  localparam int SLOT_RGB4  = 2;  // line 2
  localparam int SLOT_RGB3  = 3;  // line 2
  localparam int SLOT_RGB2  = 1;  // line 1
  localparam int SLOT_RGB1  = 2;  // line 1
  localparam int SLOT_RGB0  = 3;  // line 1

  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_e;

  typedef struct packed {
    logic [7:0] rgb;
    logic       de;
    logic       vsync;
    logic       hsync;
  } pixel_t;

  typedef logic [NUM_LANES-1:0][WORD_W-1:0] window_t;

  function automatic pixel_t unpack_word(input window_t w);
    pixel_t p;
    p.de     = w[LANE_3][SLOT_DE];
    p.vsync  = w[LANE_3][SLOT_VSYNC];
    p.hsync  = w[LANE_3][SLOT_HSYNC];
    p.rgb[7] = w[LANE_3][SLOT_RGB7];
    p.rgb[6] = w[LANE_3][SLOT_RGB6];
    p.rgb[5] = w[LANE_3][SLOT_RGB5];
    p.rgb[4] = w[LANE_2][SLOT_RGB4];
    p.rgb[3] = w[LANE_2][SLOT_RGB3];
    p.rgb[2] = w[LANE_1][SLOT_RGB2];
    p.rgb[1] = w[LANE_1][SLOT_RGB1];
    p.rgb[0] = w[LANE_1][SLOT_RGB0];
    return p;
  endfunction
endpackage

// File: rtl/lvds_to_parallel_if.sv
// Serial LVDS lines in, recovered pixel stream and link status out.
interface lvds_to_parallel_if;
  logic       lvdsIn1;
  logic       lvdsIn2;
  logic       lvdsIn3;
  logic       lvdsClkIn;
  logic [7:0] rgbOut;
  logic       deOut;
  logic       vsyncOut;
  logic       hsyncOut;
  logic       pixelValid;
  logic       locked;
  logic [7:0] syncErrors;

  modport master (
    output lvdsIn1, lvdsIn2, lvdsIn3, lvdsClkIn,
    input  rgbOut, deOut, vsyncOut, hsyncOut, pixelValid, locked, syncErrors
  );
  modport slave (
    input  lvdsIn1, lvdsIn2, lvdsIn3, lvdsClkIn,
    output rgbOut, deOut, vsyncOut, hsyncOut, pixelValid, locked, syncErrors
  );
endinterface

// File: rtl/lvds_deser_lane.sv
// One serial lane: input flop, optional SKEW-stage delay, 7-bit window.
// window[0] holds the oldest sample.
module lvds_deser_lane
  import lvds_pkg::*;
#(
  parameter int SKEW = 0
) (
  input  logic              lvdsInputClock,
  input  logic              resetN,
  input  logic              serial_in,
  output logic [WORD_W-1:0] window
);
  logic              in_q;
  logic              tap;
  logic [WORD_W-1:0] sr_q, sr_d;

  always_ff @(posedge lvdsInputClock or negedge resetN)
    if (!resetN) in_q <= 1'b0;
    else         in_q <= serial_in;

  if (SKEW == 0) begin : g_nodly
    assign tap = in_q;
  end else begin : g_dly
    logic dly_q [SKEW];
    always_ff @(posedge lvdsInputClock or negedge resetN)
      if (!resetN) begin
        for (int i = 0; i < SKEW; i++) dly_q[i] <= 1'b0;
      end else begin
        dly_q[0] <= in_q;
        for (int i = 1; i < SKEW; i++) dly_q[i] <= dly_q[i-1];
      end
    assign tap = dly_q[SKEW-1];
  end

  always_comb sr_d = {tap, sr_q[WORD_W-1:1]};

  always_ff @(posedge lvdsInputClock or negedge resetN)
    if (!resetN) sr_q <= '0;
    else         sr_q <= sr_d;

  assign window = sr_q;
endmodule

// File: rtl/lvds_to_parallel.sv
// 7:1 LVDS receiver: locks to the forwarded clock-line pattern, then unpacks
// each 7-slot word of the three data lines into rgb/de/vsync/hsync.
module lvds_to_parallel
  import lvds_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 2,
  parameter int DATA_SKEW  = 0
) (
  input logic                lvdsInputClock,
  input logic                resetN,
  lvds_to_parallel_if.slave  bus
);
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] ERR_N  = 4'(ERR_LIMIT);

  logic [NUM_LANES-1:0] serial;
  window_t              win;

  assign serial[LANE_CLK] = bus.lvdsClkIn;
  assign serial[LANE_1]   = bus.lvdsIn1;
  assign serial[LANE_2]   = bus.lvdsIn2;
  assign serial[LANE_3]   = bus.lvdsIn3;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lvds_deser_lane #(.SKEW(i == LANE_CLK ? 0 : DATA_SKEW)) u_lane (
      .lvdsInputClock (lvdsInputClock),
      .resetN         (resetN),
      .serial_in      (serial[i]),
      .window         (win[i])
    );
  end

  state_e     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [3:0] good_q, good_d;
  logic [3:0] err_q, err_d;
  logic [7:0] serr_q, serr_d;
  pixel_t     pix_q, pix_d;
  logic       pv_q, pv_d;
  logic       locked_q, locked_d;

  logic   clk_match, boundary;
  pixel_t word;

  assign clk_match = (win[LANE_CLK] == CLK_PATTERN);
  assign boundary  = (slot_q == 3'(WORD_W-1));
  assign word      = unpack_word(win);

  always_comb begin
    state_d  = state_q;
    slot_d   = boundary ? 3'd0 : slot_q + 3'd1;
    good_d   = good_q;
    err_d    = err_q;
    serr_d   = serr_q;
    pix_d    = pix_q;
    pv_d     = 1'b0;
    locked_d = locked_q;
    unique case (state_q)
      SEARCH: begin
        // Compared every cycle; a match defines the word phase from here on.
        if (clk_match) begin
          slot_d = 3'd0;
          good_d = 4'd1;
          if (LOCK_N == 4'd1) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
            err_d    = 4'd0;
            pix_d    = word;
            pv_d     = 1'b1;
          end else begin
            state_d = LOCKING;
          end
        end
      end
      LOCKING: begin
        if (boundary) begin
          if (clk_match) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == LOCK_N) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              err_d    = 4'd0;
              pix_d    = word;
              pv_d     = 1'b1;
            end
          end else begin
            state_d = SEARCH;
            good_d  = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          if (clk_match) begin
            pix_d = word;
            pv_d  = 1'b1;
            err_d = 4'd0;
          end else begin
            if (serr_q != 8'hFF) serr_d = serr_q + 8'd1;
            if (err_q + 4'd1 == ERR_N) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              pix_d.de = 1'b0;
              err_d    = 4'd0;
              good_d   = 4'd0;
            end else begin
              err_d = err_q + 4'd1;
            end
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge lvdsInputClock or negedge resetN)
    if (!resetN) begin
      state_q  <= SEARCH;
      slot_q   <= 3'd0;
      good_q   <= 4'd0;
      err_q    <= 4'd0;
      serr_q   <= 8'd0;
      pix_q    <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      good_q   <= good_d;
      err_q    <= err_d;
      serr_q   <= serr_d;
      pix_q    <= pix_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
    end

  assign bus.rgbOut     = pix_q.rgb;
  assign bus.deOut      = pix_q.de;
  assign bus.vsyncOut   = pix_q.vsync;
  assign bus.hsyncOut   = pix_q.hsync;
  assign bus.pixelValid = pv_q;
  assign bus.locked     = locked_q;
  assign bus.syncErrors = serr_q;
endmodule
